iic_slave_regs: RTL and testbench

// - I2C target (responder) for the camera configuration bus: the other end of the IIC master that writes 24-bit config words.
// - Decodes device address, ADDR_BYTES-byte register pointer, write/read data; presents a simple register-port to a register model.
// - Used as camera-side bus model in simulation and as an on-FPGA config target. All logic runs in the 50 MHz system clock domain; SCL/SDA are oversampled.

---
 rtl/iic_pkg.sv | 37 +++
 rtl/iic_slave_regs_if.sv | 34 +++
 rtl/iic_line_sync.sv | 53 +++++
 rtl/iic_slave_regs.sv | 198 +++++++++++++++++++
 tb/tb_iic_slave_regs.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the I2C register target: FSM state encoding,
// bus-level ACK/NACK levels, bit-counter width and pointer arithmetic.
package iic_pkg;

  localparam int unsigned BIT_CNT_W  = 3;
  localparam int unsigned REG_ADDR_W = 16;
  localparam int unsigned REG_DATA_W = 8;

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = 3'd7;

  // SDA level seen in an acknowledge slot
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } iic_state_e;

  // Register pointer increment; wraps within the configured pointer width
  function automatic logic [REG_ADDR_W-1:0] ptr_inc(input logic [REG_ADDR_W-1:0] ptr,
                                                    input int unsigned addr_bytes);
    if (addr_bytes == 1) begin
      return {8'h00, 8'(ptr[7:0] + 8'd1)};
    end
    return 16'(ptr + 16'd1);
  endfunction

endpackage

// File: rtl/iic_slave_regs_if.sv
// Register-port bundle between the I2C target and a register model.
//   reg_addr  : register pointer
//   reg_wdata : write data, valid with reg_wr
//   reg_wr    : one-clk write strobe
//   reg_rd    : one-clk read request, reg_rdata sampled the following clk
//   reg_rdata : read data returned by the register model
interface iic_slave_regs_if;
  import iic_pkg::*;

  logic [REG_ADDR_W-1:0] reg_addr;
  logic [REG_DATA_W-1:0] reg_wdata;
  logic                  reg_wr;
  logic                  reg_rd;
  logic [REG_DATA_W-1:0] reg_rdata;

  // I2C target side drives the request
  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_wr,
    output reg_rd,
    input  reg_rdata
  );

  // Register model side answers reads
  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr,
    input  reg_rd,
    output reg_rdata
  );

endinterface

// File: rtl/iic_line_sync.sv
// SCL/SDA oversampling: 2-FF synchronizers plus one history stage, with
// registered edge and START/STOP condition pulses.
//   clk, rst_n  : system clock, async active-low reset
//   scl_raw     : asynchronous bus clock
//   sda_raw     : asynchronous bus data
//   scl_rise    : one-clk pulse, synchronized SCL rose
//   scl_fall    : one-clk pulse, synchronized SCL fell
//   start_det   : one-clk pulse, SDA fell while SCL high
//   stop_det    : one-clk pulse, SDA rose while SCL high
//   sda_synced  : synchronized SDA aligned with the pulses above
module iic_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_synced
);

  logic [1:0] scl_meta;
  logic [1:0] sda_meta;
  logic       scl_hist;
  logic       sda_hist;

  // Idle bus is high, so synchronizers reset high to avoid a false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta  <= 2'b11;
      sda_meta  <= 2'b11;
      scl_hist  <= 1'b1;
      sda_hist  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_meta  <= {scl_meta[0], scl_raw};
      sda_meta  <= {sda_meta[0], sda_raw};
      scl_hist  <= scl_meta[1];
      sda_hist  <= sda_meta[1];
      scl_rise  <= scl_meta[1] & ~scl_hist;
      scl_fall  <= ~scl_meta[1] & scl_hist;
      start_det <= scl_meta[1] & scl_hist & sda_hist & ~sda_meta[1];
      stop_det  <= scl_meta[1] & scl_hist & ~sda_hist & sda_meta[1];
    end
  end

  assign sda_synced = sda_hist;

endmodule

// File: rtl/iic_slave_regs.sv
// I2C target for the camera configuration bus. Decodes the device address,
// an ADDR_BYTES-byte register pointer and write/read data, and presents a
// simple register port. SCL/SDA are oversampled in the clk domain.
//   clk, rst_n : system clock, async active-low reset
//   iic_scl    : bus clock from the master
//   iic_sda    : open-drain bus data (driven 0 or z only)
//   regs       : register port (addr/wdata/wr/rd out, rdata in)
//   busy       : high from address-match ACK until STOP/START/NACK abort
module iic_slave_regs
  import iic_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h3c,
  parameter int unsigned ADDR_BYTES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iic_scl,
  inout  wire               iic_sda,
  iic_slave_regs_if.master  regs,
  output logic              busy
);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_q;

  iic_line_sync u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_raw    (iic_scl),
    .sda_raw    (iic_sda),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .sda_synced (sda_q)
  );

  iic_state_e            state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [7:0]            shreg;
  logic [REG_ADDR_W-1:0] ptr;
  logic                  ptr_byte;
  logic                  rnw;
  logic                  mack;
  logic                  rd_load;
  logic                  sda_oe;
  logic                  reg_wr;
  logic                  reg_rd;
  logic [REG_DATA_W-1:0] wdata;
  logic [7:0]            rx_byte;
  logic                  last_ptr_byte;

  assign rx_byte       = {shreg[6:0], sda_q};
  assign last_ptr_byte = (ADDR_BYTES == 1) || ptr_byte;

  // Protocol FSM; START/STOP take precedence over every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      ptr_byte <= 1'b0;
      rnw      <= 1'b0;
      mack     <= 1'b0;
      rd_load  <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      wdata    <= '0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (start_det || stop_det) begin
        // Partial bytes are dropped; the pointer survives a repeated START
        state   <= start_det ? DEV_ADDR : IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        rd_load <= 1'b0;
        mack    <= 1'b0;
      end else begin
        // Read data arrives one clk after the reg_rd strobe; present bit 7
        if (rd_load) begin
          rd_load <= 1'b0;
          shreg   <= regs.reg_rdata;
          sda_oe  <= ~regs.reg_rdata[7];
        end
        case (state)
          DEV_ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= BIT_CNT_W'(bit_cnt + 1'b1);
              if (bit_cnt == BIT_LAST) begin
                if (state == DEV_ADDR) begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    state <= DEV_ACK;
                    busy  <= 1'b1;
                    rnw   <= rx_byte[0];
                  end else begin
                    state <= WAIT_STOP;
                  end
                end else if (state == PTR) begin
                  if (ADDR_BYTES == 1) begin
                    ptr <= {8'h00, rx_byte};
                  end else if (!ptr_byte) begin
                    ptr[15:8] <= rx_byte;
                  end else begin
                    ptr[7:0] <= rx_byte;
                  end
                  state <= PTR_ACK;
                end else begin
                  wdata  <= rx_byte;
                  reg_wr <= 1'b1;
                  state  <= WDATA_ACK;
                end
              end
            end
          end
          // First SCL fall starts the ACK drive, second fall ends the slot
          DEV_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                if (state == DEV_ACK) begin
                  if (rnw) begin
                    state   <= RDATA;
                    reg_rd  <= 1'b1;
                    rd_load <= 1'b1;
                  end else begin
                    state    <= PTR;
                    ptr_byte <= 1'b0;
                  end
                end else if (state == PTR_ACK) begin
                  if (last_ptr_byte) begin
                    state <= WDATA;
                  end else begin
                    ptr_byte <= 1'b1;
                    state    <= PTR;
                  end
                end else begin
                  ptr   <= ptr_inc(ptr, ADDR_BYTES);
                  state <= WDATA;
                end
              end
            end
          end
          // Bits 6..0 follow on successive falls; the 8th fall frees SDA
          RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == BIT_LAST) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= RDATA_ACK;
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                sda_oe  <= ~shreg[6];
                bit_cnt <= BIT_CNT_W'(bit_cnt + 1'b1);
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_q == NACK) begin
                state <= WAIT_STOP;
                busy  <= 1'b0;
              end else begin
                mack <= 1'b1;
                ptr  <= ptr_inc(ptr, ADDR_BYTES);
              end
            end else if (scl_fall && mack) begin
              mack    <= 1'b0;
              reg_rd  <= 1'b1;
              rd_load <= 1'b1;
              state   <= RDATA;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign iic_sda        = sda_oe ? 1'b0 : 1'bz;
  assign regs.reg_addr  = ptr;
  assign regs.reg_wdata = wdata;
  assign regs.reg_wr    = reg_wr;
  assign regs.reg_rd    = reg_rd;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bench for iic_slave_regs: a bit-banged I2C master, a register-port
// monitor, table-driven write transactions and directed read/abort/reset
// sequences.
module tb_iic_slave_regs;
  import iic_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_sda_low;
  logic       busy;
  logic [7:0] rdata_model;
  wire        sda;

  iic_slave_regs_if bus ();

  pullup (sda);
  assign sda           = m_sda_low ? 1'b0 : 1'bz;
  assign bus.reg_rdata = rdata_model;

  iic_slave_regs #(.SLAVE_ADDR(7'h3c), .ADDR_BYTES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iic_scl (scl),
    .iic_sda (sda),
    .regs    (bus),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  // Register-port monitor
  logic [15:0] wr_addr_log [64];
  logic [7:0]  wr_data_log [64];
  logic [15:0] rd_addr_log [64];
  int          wr_n = 0;
  int          rd_n = 0;

  always @(posedge clk) begin
    if (bus.reg_wr && wr_n < 64) begin
      wr_addr_log[wr_n] <= bus.reg_addr;
      wr_data_log[wr_n] <= bus.reg_wdata;
      wr_n              <= wr_n + 1;
    end
    if (bus.reg_rd && rd_n < 64) begin
      rd_addr_log[rd_n] <= bus.reg_addr;
      rd_n              <= rd_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      m_sda_low = 1'b0;
      wait_clks(Q);
      scl = 1'b1;
      wait_clks(Q);
    end
    m_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    m_sda_low = 1'b0;
    wait_clks(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(2 * Q);
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    b = sda;
    wait_clks(Q);
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  // Reads a byte, then loads the next register value before the ACK slot
  task automatic read_byte(output logic [7:0] d, input logic mack, input logic [7:0] nxt);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    rdata_model = nxt;
    write_bit(mack);
  endtask

  typedef struct {
    logic [6:0]        dev;
    logic [15:0]       ptr;
    int                n;
    logic [2:0][7:0]   data;
    logic              exp_ack;
    int                exp_wr;
    logic [2:0][15:0]  exp_addr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         wr_base;
    int         rd_base;

    vecs[0] = '{dev: 7'h3c, ptr: 16'h3008, n: 1, data: {8'h00, 8'h00, 8'h82},
                exp_ack: ACK, exp_wr: 1, exp_addr: {16'h0000, 16'h0000, 16'h3008}};
    vecs[1] = '{dev: 7'h3d, ptr: 16'h3008, n: 1, data: {8'h00, 8'h00, 8'h82},
                exp_ack: NACK, exp_wr: 0, exp_addr: {16'h0000, 16'h0000, 16'h0000}};
    vecs[2] = '{dev: 7'h3c, ptr: 16'h3008, n: 3, data: {8'h33, 8'h22, 8'h11},
                exp_ack: ACK, exp_wr: 3, exp_addr: {16'h300a, 16'h3009, 16'h3008}};
    vecs[3] = '{dev: 7'h3c, ptr: 16'hffff, n: 2, data: {8'h00, 8'hbb, 8'haa},
                exp_ack: ACK, exp_wr: 2, exp_addr: {16'h0000, 16'h0000, 16'hffff}};

    rst_n       = 1'b0;
    scl         = 1'b1;
    m_sda_low   = 1'b0;
    rdata_model = 8'h00;
    wait_clks(5);
    check("reset sda", 32'(sda), 32'(1'b1));
    check("reset busy", 32'(busy), 32'(1'b0));
    check("reset reg_wr", 32'(bus.reg_wr), 32'(1'b0));
    check("reset reg_rd", 32'(bus.reg_rd), 32'(1'b0));
    check("reset reg_addr", 32'(bus.reg_addr), 32'h0);
    check("reset reg_wdata", 32'(bus.reg_wdata), 32'h0);
    rst_n = 1'b1;
    wait_clks(5);

    // Table-driven write transactions
    for (int v = 0; v < 4; v++) begin
      wr_base = wr_n;
      i2c_start();
      write_byte({vecs[v].dev, 1'b0}, ack);
      check($sformatf("v%0d dev ack", v), 32'(ack), 32'(vecs[v].exp_ack));
      check($sformatf("v%0d busy after addr", v), 32'(busy), 32'(vecs[v].exp_ack == ACK));
      if (vecs[v].exp_ack == ACK) begin
        write_byte(vecs[v].ptr[15:8], ack);
        check($sformatf("v%0d ptr hi ack", v), 32'(ack), 32'(ACK));
        write_byte(vecs[v].ptr[7:0], ack);
        check($sformatf("v%0d ptr lo ack", v), 32'(ack), 32'(ACK));
        for (int i = 0; i < vecs[v].n; i++) begin
          write_byte(vecs[v].data[i], ack);
          check($sformatf("v%0d data%0d ack", v, i), 32'(ack), 32'(ACK));
        end
        check($sformatf("v%0d busy before stop", v), 32'(busy), 32'(1'b1));
      end
      i2c_stop();
      check($sformatf("v%0d busy after stop", v), 32'(busy), 32'(1'b0));
      check($sformatf("v%0d sda after stop", v), 32'(sda), 32'(1'b1));
      check($sformatf("v%0d wr count", v), 32'(wr_n - wr_base), 32'(vecs[v].exp_wr));
      for (int i = 0; i < vecs[v].exp_wr; i++) begin
        if (wr_base + i < 64) begin
          check($sformatf("v%0d wr%0d addr", v, i), 32'(wr_addr_log[wr_base + i]), 32'(vecs[v].exp_addr[i]));
          check($sformatf("v%0d wr%0d data", v, i), 32'(wr_data_log[wr_base + i]), 32'(vecs[v].data[i]));
        end
      end
    end

    // Pointer write, repeated START, two-byte read with ACK then NACK
    wr_base     = wr_n;
    rd_base     = rd_n;
    rdata_model = 8'ha5;
    i2c_start();
    write_byte(8'h78, ack);
    check("rd dev W ack", 32'(ack), 32'(ACK));
    write_byte(8'h30, ack);
    check("rd ptr hi ack", 32'(ack), 32'(ACK));
    write_byte(8'h0a, ack);
    check("rd ptr lo ack", 32'(ack), 32'(ACK));
    i2c_start();
    write_byte(8'h79, ack);
    check("rd dev R ack", 32'(ack), 32'(ACK));
    read_byte(rb, ACK, 8'h5a);
    check("rd byte0", 32'(rb), 32'ha5);
    read_byte(rb, NACK, 8'h00);
    check("rd byte1", 32'(rb), 32'h5a);
    wait_clks(2);
    check("rd sda after nack", 32'(sda), 32'(1'b1));
    check("rd busy after nack", 32'(busy), 32'(1'b0));
    i2c_stop();
    check("rd reg_rd count", 32'(rd_n - rd_base), 32'd2);
    check("rd addr0", 32'(rd_addr_log[rd_base]), 32'h300a);
    check("rd addr1", 32'(rd_addr_log[rd_base + 1]), 32'h300b);
    check("rd no writes", 32'(wr_n - wr_base), 32'd0);

    // STOP after four data bits: byte discarded, pointer kept
    wr_base = wr_n;
    i2c_start();
    write_byte(8'h78, ack);
    write_byte(8'h12, ack);
    write_byte(8'h34, ack);
    check("partial ptr ack", 32'(ack), 32'(ACK));
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    check("partial busy mid byte", 32'(busy), 32'(1'b1));
    i2c_stop();
    check("partial busy", 32'(busy), 32'(1'b0));
    check("partial sda", 32'(sda), 32'(1'b1));
    check("partial no write", 32'(wr_n - wr_base), 32'd0);
    check("partial ptr kept", 32'(bus.reg_addr), 32'h1234);

    // Reset asserted while the target drives read bit 0 low
    wr_base     = wr_n;
    rdata_model = 8'h00;
    i2c_start();
    write_byte(8'h78, ack);
    write_byte(8'h40, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'h79, ack);
    check("rst dev R ack", 32'(ack), 32'(ACK));
    for (int i = 0; i < 7; i++) read_bit(ack);
    check("rst sda driven bit0", 32'(sda), 32'(1'b0));
    #3 rst_n = 1'b0;
    #1;
    check("rst sda released", 32'(sda), 32'(1'b1));
    check("rst busy", 32'(busy), 32'(1'b0));
    check("rst reg_addr", 32'(bus.reg_addr), 32'h0);
    wait_clks(3);
    rst_n = 1'b1;
    i2c_stop();
    check("rst no write", 32'(wr_n - wr_base), 32'd0);
    check("rst busy after stop", 32'(busy), 32'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
